sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: SDRAM word-address width.
REQ-002 Parameter DATA_W, default 16: SDRAM data width.
REQ-003 Parameter TIMEOUT_CYC, default 255: BUSY-cycle limit, used only under ARB_TIMEOUT_EN.
REQ-004 sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 m0_req / m1_req  in  1  request level; m0 is the UART host, m1 is the RaspberryPi bridge.
REQ-007 m0_we / m1_we  in  1  1 = write, 0 = read.
REQ-008 m0_addr / m1_addr  in  ADDR_W  word address.
REQ-009 m0_wdata / m1_wdata  in  DATA_W  write data.
REQ-010 m0_ack / m1_ack  out  1  completion, 4-phase.
REQ-011 m0_rdata / m1_rdata  out  DATA_W  read data, valid while the matching ack is high.
REQ-012 m0_err / m1_err  out  1  timeout flag, valid while the matching ack is high.
REQ-013 sd_req  out  1  level request to the SDRAM controller.
REQ-014 sd_we, sd_addr, sd_wdata  out  1/ADDR_W/DATA_W  latched command to the controller.
REQ-015 sd_ack  in  1  one-cycle completion pulse from the controller.
REQ-016 sd_rdata  in  DATA_W  read data, valid in the sd_ack cycle.
REQ-017 grant  out  1  index of the requester owning the current or last transaction.

Function
REQ-018 States: IDLE, BUSY, DONE; all outputs registered.
REQ-019 IDLE, no req: remain in IDLE.
REQ-020 IDLE, any req: pick the winner, latch its we/addr/wdata into sd_*, set grant, go to BUSY.
REQ-021 Single req: that requester wins.
REQ-022 Both req: the requester not named by last_grant wins (round-robin).
REQ-023 BUSY: sd_req = 1; sd_* stay stable until sd_ack; requester-side changes are ignored.
REQ-024 BUSY with sd_ack: drop sd_req next cycle, copy sd_rdata into the granted mN_rdata (read or write), set err = 0, assert granted mN_ack, go to DONE.
REQ-025 DONE: hold mN_ack = 1 until mN_req is sampled 0.
REQ-026 DONE exit: drop mN_ack, set last_grant = grant, go to IDLE.
REQ-027 Requesters hold the command stable from req rise until ack rise, and drop req only after ack.
REQ-028 Minimum latency: req sampled in cycle 0, sd_req high in cycle 1, sd_ack in cycle 1 gives mN_ack in cycle 2.
REQ-029 The non-granted requester's ack stays 0 throughout.
REQ-030 sd_ack outside BUSY is ignored.
REQ-031 A new req arriving during BUSY or DONE waits and is arbitrated in the next IDLE.

Reset
REQ-032 Reset values: state = IDLE, sd_req = 0, sd_we = 0, sd_addr = 0, sd_wdata = 0, mN_ack = 0, mN_rdata = 0, mN_err = 0, grant = 0, last_grant = 1 (first tie goes to m0).
REQ-033 Reset mid-transaction abandons it without a completion; the SDRAM controller is reset by the same sys_rst.

Configuration
REQ-034 With ARB_TIMEOUT_EN defined: an 8-bit counter clears on BUSY entry and counts BUSY cycles.
REQ-035 With ARB_TIMEOUT_EN defined: if the counter reaches TIMEOUT_CYC without sd_ack, drop sd_req, set mN_rdata = 0 and mN_err = 1, go to DONE.
REQ-036 Without ARB_TIMEOUT_EN: BUSY waits indefinitely, no counter exists, m0_err/m1_err are tied 0.

Structure
REQ-037 Package sdram_arb_pkg holds the state enum and default constants for ADDR_W, DATA_W and TIMEOUT_CYC.
REQ-038 Sub-module rr_arb2 holds the combinational 2-way round-robin pick (inputs req0, req1, last; output win); everything else lives in sdram_port_arbiter.

Verification
REQ-039 m0 write addr 0x000100 data 0xA5A5, sd_ack 3 cycles after sd_req -> sd_addr = 0x000100, sd_wdata = 0xA5A5, sd_we = 1, m0_ack rises the cycle after sd_ack, m1_ack stays 0.
REQ-040 m0 and m1 raise req in the same cycle after reset -> m0 served first, then m1, grant = 0 then 1, exactly two sd_req pulses.
REQ-041 Both requesters hold req continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-042 m1 read addr 0x123456 with sd_rdata = 0xBEEF at sd_ack, m1 holds req 5 cycles after ack -> m1_rdata = 0xBEEF and m1_ack stay high 5 cycles, then IDLE.
REQ-043 sys_rst pulsed in BUSY -> sd_req and all acks go 0 immediately (asynchronously), next arbitration tie goes to m0.
REQ-044 ARB_TIMEOUT_EN, sd_ack never asserted -> sd_req drops after 255 BUSY cycles, m0_ack = 1 with m0_err = 1 and m0_rdata = 0; without the macro, sd_req still high at cycle 1000.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizes for the two-port SDRAM arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } arb_state_t;

  localparam int DEF_ADDR_W      = 24;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; win is only meaningful while at least one request is present.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic win
);

  // On a tie the requester that did not own the previous transaction wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the UART host (m0) and the RaspberryPi bridge (m1) onto one SDRAM controller port.
// Define ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYC cycles and flag the requester with mN_err.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  input  logic              sd_ack,
  input  logic [DATA_W-1:0] sd_rdata,
  output logic              grant
);

  arb_state_t state;
  logic       last_grant;
  logic       win;
  logic       granted_req;

  rr_arb2 u_rr_arb2 (
    .req0 (m0_req),
    .req1 (m1_req),
    .last (last_grant),
    .win  (win)
  );

  assign granted_req = grant ? m1_req : m0_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC - 1);
  logic [7:0] busy_cnt;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      sd_req     <= 1'b0;
      sd_we      <= 1'b0;
      sd_addr    <= '0;
      sd_wdata   <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      busy_cnt   <= '0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            grant    <= win;
            sd_we    <= win ? m1_we    : m0_we;
            sd_addr  <= win ? m1_addr  : m0_addr;
            sd_wdata <= win ? m1_wdata : m0_wdata;
            sd_req   <= 1'b1;
            state    <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            busy_cnt <= '0;
`endif
          end
        end
        // The latched command stays on sd_* untouched until the controller answers.
        ST_BUSY: begin
          if (sd_ack) begin
            sd_req <= 1'b0;
            state  <= ST_DONE;
            if (grant) begin
              m1_rdata <= sd_rdata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= sd_rdata;
              m0_ack   <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            m0_err <= 1'b0;
            m1_err <= 1'b0;
          end else if (busy_cnt == TO_LIMIT) begin
            sd_req <= 1'b0;
            state  <= ST_DONE;
            if (grant) begin
              m1_rdata <= '0;
              m1_err   <= 1'b1;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= '0;
              m0_err   <= 1'b1;
              m0_ack   <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
`endif
          end
        end
        ST_DONE: begin
          if (!granted_req) begin
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter, checked against a transaction-level arbitration model.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_CYC = 255;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [ADDR_W-1:0] m_addr  [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic              m0_ack, m1_ack, m0_err, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              sd_req, sd_we, sd_ack, grant;
  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_wdata, sd_rdata;

  logic [1:0]        ack_v, err_v;
  logic [DATA_W-1:0] rdata_v [2];

  int checks   = 0;
  int failures = 0;

  // Model state: who owned the last completed transaction and what each requester last read.
  int                last_w;
  logic [DATA_W-1:0] exp_rdata [2];

  assign ack_v      = {m1_ack, m0_ack};
  assign err_v      = {m1_err, m0_err};
  assign rdata_v[0] = m0_rdata;
  assign rdata_v[1] = m1_rdata;

  always #5 sys_clk = ~sys_clk;

  sdram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .m0_req   (m_req[0]),
    .m0_we    (m_we[0]),
    .m0_addr  (m_addr[0]),
    .m0_wdata (m_wdata[0]),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_req   (m_req[1]),
    .m1_we    (m_we[1]),
    .m1_addr  (m_addr[1]),
    .m1_wdata (m_wdata[1]),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .sd_req   (sd_req),
    .sd_we    (sd_we),
    .sd_addr  (sd_addr),
    .sd_wdata (sd_wdata),
    .sd_ack   (sd_ack),
    .sd_rdata (sd_rdata),
    .grant    (grant)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic new_command(input int m);
    m_we[m]    = 1'($urandom_range(0, 1));
    m_addr[m]  = ADDR_W'($urandom);
    m_wdata[m] = DATA_W'($urandom);
    m_req[m]   = 1'b1;
  endtask

  function automatic int predict_winner();
    if (m_req == 2'b11) return 1 - last_w;
    return m_req[1] ? 1 : 0;
  endfunction

  // One full transaction starting at a negedge with the arbiter idle and a request pending.
  task automatic applyStimulus(input int lat, input int hold, input logic [DATA_W-1:0] rd);
    int         w;
    logic [1:0] exp_ack;
    w       = predict_winner();
    exp_ack = (w == 1) ? 2'b10 : 2'b01;
    @(posedge sys_clk); @(negedge sys_clk);
    checkOutput("sd_req_rise", sd_req, 1);
    checkOutput("grant", grant, w);
    checkOutput("sd_we", sd_we, m_we[w]);
    checkOutput("sd_addr", sd_addr, m_addr[w]);
    checkOutput("sd_wdata", sd_wdata, m_wdata[w]);
    checkOutput("ack_idle", ack_v, 2'b00);
    for (int i = 0; i < lat; i++) begin
      if (!m_req[1-w] && $urandom_range(0, 2) == 0) new_command(1 - w);
      @(posedge sys_clk); @(negedge sys_clk);
      checkOutput("busy_hold", {sd_req, ack_v}, 3'b100);
      checkOutput("busy_addr", sd_addr, m_addr[w]);
    end
    sd_rdata = rd;
    sd_ack   = 1'b1;
    @(posedge sys_clk); @(negedge sys_clk);
    sd_ack       = 1'b0;
    sd_rdata     = DATA_W'($urandom);
    exp_rdata[w] = rd;
    checkOutput("ack_rise", ack_v, exp_ack);
    checkOutput("sd_req_fall", sd_req, 0);
    checkOutput("rdata0", rdata_v[0], exp_rdata[0]);
    checkOutput("rdata1", rdata_v[1], exp_rdata[1]);
    checkOutput("err", err_v, 2'b00);
    for (int i = 0; i < hold; i++) begin
      if ($urandom_range(0, 1) == 1) sd_ack = 1'b1;
      if (!m_req[1-w] && $urandom_range(0, 2) == 0) new_command(1 - w);
      @(posedge sys_clk); @(negedge sys_clk);
      sd_ack = 1'b0;
      checkOutput("ack_hold", {sd_req, ack_v}, {1'b0, exp_ack});
      checkOutput("rdata_hold", rdata_v[w], rd);
    end
    m_req[w] = 1'b0;
    last_w   = w;
    @(posedge sys_clk); @(negedge sys_clk);
    checkOutput("ack_fall", {sd_req, ack_v}, 3'b000);
  endtask

  initial begin
    int w;
    int cnt;
    m_req      = 2'b00;
    m_we       = 2'b00;
    m_addr[0]  = '0;
    m_addr[1]  = '0;
    m_wdata[0] = '0;
    m_wdata[1] = '0;
    sd_ack     = 1'b0;
    sd_rdata   = '0;
    last_w     = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;

    #1 sys_rst = 1'b1;
    #11;
    checkOutput("rst_sd_req", sd_req, 0);
    checkOutput("rst_sd_cmd", {sd_we, sd_addr, sd_wdata}, '0);
    checkOutput("rst_acks", ack_v, 2'b00);
    checkOutput("rst_err", err_v, 2'b00);
    checkOutput("rst_rdata", {m1_rdata, m0_rdata}, '0);
    checkOutput("rst_grant", grant, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    $display("[TB] m0 write with three-cycle controller latency");
    m_we[0]    = 1'b1;
    m_addr[0]  = 24'h000100;
    m_wdata[0] = 16'hA5A5;
    m_req[0]   = 1'b1;
    applyStimulus(3, 2, 16'h0000);

    $display("[TB] simultaneous requests");
    new_command(0);
    new_command(1);
    applyStimulus(1, 0, DATA_W'($urandom));
    applyStimulus(2, 1, DATA_W'($urandom));

    $display("[TB] m1 read holding req after ack");
    m_we[1]   = 1'b0;
    m_addr[1] = 24'h123456;
    m_req[1]  = 1'b1;
    applyStimulus(0, 4, 16'hBEEF);

    $display("[TB] continuous contention");
    repeat (6) begin
      if (!m_req[0]) new_command(0);
      if (!m_req[1]) new_command(1);
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 2), DATA_W'($urandom));
    end

    $display("[TB] random traffic");
    repeat (40) begin
      for (int m = 0; m < 2; m++)
        if (!m_req[m] && $urandom_range(0, 1) == 1) new_command(m);
      if (m_req == 2'b00) new_command(int'($urandom_range(0, 1)));
      applyStimulus($urandom_range(0, 4), $urandom_range(0, 5), DATA_W'($urandom));
    end

    $display("[TB] reset during BUSY");
    if (m_req == 2'b00) new_command(0);
    @(posedge sys_clk); @(negedge sys_clk);
    checkOutput("pre_rst_busy", sd_req, 1);
    #2 sys_rst = 1'b1;
    #1;
    checkOutput("async_rst_clear", {sd_req, ack_v, grant}, 4'b0000);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    last_w       = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    new_command(0);
    new_command(1);
    applyStimulus(1, 0, DATA_W'($urandom));
    applyStimulus(0, 0, DATA_W'($urandom));

    $display("[TB] controller never answers");
    new_command(0);
    w = predict_winner();
    @(posedge sys_clk); @(negedge sys_clk);
    checkOutput("stall_sd_req", sd_req, 1);
`ifdef ARB_TIMEOUT_EN
    cnt = 1;
    while (sd_req && cnt < 400) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (sd_req) cnt++;
    end
    checkOutput("timeout_cycles", cnt, TIMEOUT_CYC);
    checkOutput("timeout_ack", ack_v[w], 1);
    checkOutput("timeout_err", err_v[w], 1);
    checkOutput("timeout_rdata", rdata_v[w], 0);
`else
    cnt = 0;
    repeat (1000) begin
      @(posedge sys_clk);
      cnt++;
    end
    @(negedge sys_clk);
    checkOutput("no_timeout_sd_req", sd_req, 1);
    checkOutput("no_timeout_ack", {ack_v, err_v}, 4'b0000);
    checkOutput("no_timeout_grant", grant, w);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
